// File: rtl/pc_stall_ctrl.sv
// PC increment control: stalls the program counter for multi-cycle multiplies and
// for wait-for-button instructions, with a synchronised, debounced button input.
module pc_stall_ctrl #(
    parameter int               Osize      = 3,
    parameter logic [Osize-1:0] WAIT_OP    = 3'b110,
    parameter logic [Osize-1:0] MUL_OP     = 3'b101,
    parameter int               MUL_CYCLES = 3,
    parameter int               DEB_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [Osize-1:0] opcode,
    input  logic             btn,
    output logic             PCincr,
    output logic             waiting
);

    typedef enum logic [1:0] {
        RUN,
        MUL_STALL,
        WAIT_PRESS,
        WAIT_RELEASE
    } state_t;

    localparam int              DW         = $clog2(DEB_CYCLES + 1);
    localparam logic [DW-1:0]   DEB_LAST   = DW'(DEB_CYCLES - 1);
    localparam int              MW         = (MUL_CYCLES > 2) ? $clog2(MUL_CYCLES - 1) : 1;
    localparam logic [MW-1:0]   MUL_LOAD   = (MUL_CYCLES > 2) ? MW'(MUL_CYCLES - 2) : '0;
    localparam bit              MUL_STALLS = (MUL_CYCLES > 1);

    logic          s1, bs;
    logic          db, db_prev;
    logic [DW-1:0] dc;
    logic          db_rise, db_fall;
    state_t        state_q, state_d;
    logic [MW-1:0] mc_q, mc_d;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= 1'b0;
            bs <= 1'b0;
        end else begin
            s1 <= btn;
            bs <= s1;
        end
    end

    // Accept a new level only after it has differed from db for DEB_CYCLES edges.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dc      <= '0;
            db      <= 1'b0;
            db_prev <= 1'b0;
        end else begin
            db_prev <= db;
            if (bs == db) begin
                dc <= '0;
            end else if (dc == DEB_LAST) begin
                db <= ~db;
                dc <= '0;
            end else begin
                dc <= dc + DW'(1);
            end
        end
    end

    assign db_rise = db & ~db_prev;
    assign db_fall = ~db & db_prev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            mc_q    <= '0;
        end else begin
            state_q <= state_d;
            mc_q    <= mc_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        mc_d    = mc_q;
        PCincr  = 1'b0;
        case (state_q)
            RUN: begin
                if (MUL_STALLS && (opcode == MUL_OP)) begin
                    state_d = MUL_STALL;
                    mc_d    = MUL_LOAD;
                end else if (opcode == WAIT_OP) begin
                    state_d = WAIT_PRESS;
                end else begin
                    PCincr = 1'b1;
                end
            end
            MUL_STALL: begin
                if (mc_q == '0) begin
                    PCincr  = 1'b1;
                    state_d = RUN;
                end else begin
                    mc_d = mc_q - MW'(1);
                end
            end
            WAIT_PRESS: begin
                if (db_rise) state_d = WAIT_RELEASE;
            end
            WAIT_RELEASE: begin
                // Single advance on release; the next cycle is back in RUN.
                if (db_fall) begin
                    PCincr  = 1'b1;
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    assign waiting = (state_q == WAIT_PRESS) || (state_q == WAIT_RELEASE);

endmodule

// File: tb/tb_pc_stall_ctrl.sv
// Scoreboard bench for pc_stall_ctrl: stimulus pushes hand-computed {PCincr,waiting}
// per cycle; an independent monitor pops and compares on every falling edge.
module tb_pc_stall_ctrl;

    logic       clk;
    logic       rst;
    logic [2:0] opcode;
    logic       btn;
    logic       PCincr;
    logic       waiting;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic  pc;
        logic  w;
        string name;
    } exp_t;

    exp_t sb[$];

    pc_stall_ctrl #(
        .Osize     (3),
        .WAIT_OP   (3'b110),
        .MUL_OP    (3'b101),
        .MUL_CYCLES(3),
        .DEB_CYCLES(4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .opcode (opcode),
        .btn    (btn),
        .PCincr (PCincr),
        .waiting(waiting)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got {PCincr,waiting}=%b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus: drive just after the rising edge and queue the expectation.
    task automatic step(input logic [2:0] op, input logic b, input logic pc, input logic w,
                        input string name);
        exp_t e;
        @(posedge clk);
        #1;
        opcode = op;
        btn    = b;
        e.pc   = pc;
        e.w    = w;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic steps(input logic [2:0] op, input logic b, input int n, input logic pc,
                         input logic w, input string name);
        for (int i = 0; i < n; i++) step(op, b, pc, w, name);
    endtask

    task automatic drain();
        for (int i = 0; i < 8 && sb.size() != 0; i++) @(negedge clk);
        #1;
        check("sb_drain", {1'b0, sb.size() == 0}, 2'b01);
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            check(e.name, {PCincr, waiting}, {e.pc, e.w});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b0;
        opcode = 3'b000;
        btn    = 1'b0;
        #3;
        check("reset_outputs", {PCincr, waiting}, 2'b10);
        #9;
        rst = 1'b1;

        // 1. Free-running RUN
        steps(3'b000, 1'b0, 4, 1'b1, 1'b0, "run");

        // 2. Multiply stall; opcodes during the stall are ignored
        step(3'b101, 1'b0, 1'b0, 1'b0, "mul_n");
        step(3'b110, 1'b0, 1'b0, 1'b0, "mul_n1");
        step(3'b110, 1'b0, 1'b1, 1'b0, "mul_n2");
        steps(3'b000, 1'b0, 2, 1'b1, 1'b0, "mul_back_run");

        // 3. Enter WAIT and reject a 2-cycle glitch
        step(3'b110, 1'b0, 1'b0, 1'b0, "wait_enter");
        steps(3'b110, 1'b1, 2, 1'b0, 1'b1, "glitch_pulse");
        steps(3'b000, 1'b0, 8, 1'b0, 1'b1, "glitch_after");

        // 4. Press 10 cycles, release: one advance in the 7th release cycle
        steps(3'b110, 1'b1, 10, 1'b0, 1'b1, "press_hold");
        steps(3'b110, 1'b0, 6, 1'b0, 1'b1, "release_debounce");
        step(3'b110, 1'b0, 1'b1, 1'b1, "release_advance");
        steps(3'b000, 1'b0, 3, 1'b1, 1'b0, "release_run");

        // 5. Button already held when WAIT arrives
        steps(3'b000, 1'b1, 8, 1'b1, 1'b0, "preheld_run");
        step(3'b110, 1'b1, 1'b0, 1'b0, "preheld_enter");
        steps(3'b110, 1'b1, 4, 1'b0, 1'b1, "preheld_hold");
        steps(3'b110, 1'b0, 8, 1'b0, 1'b1, "preheld_release");
        steps(3'b110, 1'b1, 8, 1'b0, 1'b1, "fresh_press");
        steps(3'b110, 1'b0, 6, 1'b0, 1'b1, "fresh_release");
        step(3'b110, 1'b0, 1'b1, 1'b1, "fresh_advance");
        steps(3'b000, 1'b0, 3, 1'b1, 1'b0, "fresh_run");

        // 6. Reset in the second cycle of a multiply
        step(3'b101, 1'b0, 1'b0, 1'b0, "rst_mul_n");
        @(posedge clk);
        #1;
        opcode = 3'b000;
        #1;
        check("stall_before_rst", {PCincr, waiting}, 2'b00);
        #1;
        rst = 1'b0;
        #1;
        check("rst_mid_stall", {PCincr, waiting}, 2'b10);
        @(posedge clk);
        #3;
        rst = 1'b1;
        steps(3'b000, 1'b0, 3, 1'b1, 1'b0, "post_rst_run");
        step(3'b101, 1'b0, 1'b0, 1'b0, "post_rst_mul_n");
        step(3'b000, 1'b0, 1'b0, 1'b0, "post_rst_mul_n1");
        step(3'b000, 1'b0, 1'b1, 1'b0, "post_rst_mul_n2");
        steps(3'b000, 1'b0, 2, 1'b1, 1'b0, "post_rst_final");

        drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_stall_ctrl.md
# pc_stall_ctrl

Control stage directly upstream of the program counter. It generates the PC's increment enable (`PCincr`) from the current instruction's opcode. It stalls the PC for multi-cycle multiply instructions and for the wait-for-input instruction that the affine-transform program uses to read switch data. It also synchronises and debounces the raw pushbutton that releases a waiting program.

## Interface

Parameters:
- `Osize`, 3: opcode field width.
- `WAIT_OP`, 3'b110: wait-for-button opcode.
- `MUL_OP`, 3'b101: multiply opcode.
- `MUL_CYCLES`, 3: total cycles a multiply occupies (≥1).
- `DEB_CYCLES`, 4: consecutive stable cycles required to accept a button level change (≥1).

Ports:
- `clk` in 1: system clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-low; shared with the PC.
- `opcode` in `Osize`: opcode of the instruction at the current PC (combinational from program memory).
- `btn` in 1: raw pushbutton, active-high, asynchronous to `clk`, may bounce.
- `PCincr` out 1: PC advances on the next rising edge when 1.
- `waiting` out 1: high while stalled on `WAIT_OP` (status LED).

## Operation

**Button path**
- Two-flop synchroniser `btn` -> `bs`, both flops reset to 0.
- Debounced level `db` is registered and resets to 0.
- Debounce counter `dc` resets to 0; its width is clog2(`DEB_CYCLES`+1).
- If `bs`==`db`: `dc` clears to 0.
- Else, if `dc`==`DEB_CYCLES`-1: `db` toggles and `dc` clears.
- Else: `dc` increments.
- `db_prev` is a registered copy of `db` (reset 0). `db_rise` = `db`&!`db_prev`; `db_fall` = !`db`&`db_prev`.

**FSM** (Mealy on `PCincr`; reset state RUN)
- RUN:
  - `opcode`==`MUL_OP` and `MUL_CYCLES`>1: `PCincr`=0; load stall counter `mc`=`MUL_CYCLES`-2; go to MUL_STALL.
  - `opcode`==`WAIT_OP`: `PCincr`=0; go to WAIT_PRESS.
  - Otherwise (including `MUL_OP` with `MUL_CYCLES`==1): `PCincr`=1; stay in RUN.
- MUL_STALL:
  - `mc`==0: `PCincr`=1; go to RUN.
  - Else: `PCincr`=0; decrement `mc`.
  - `opcode` is ignored in this state.
- WAIT_PRESS: `PCincr`=0, `waiting`=1. On `db_rise`, go to WAIT_RELEASE.
- WAIT_RELEASE: `waiting`=1. On `db_fall`: `PCincr`=1 for that single cycle; go to RUN. Otherwise `PCincr`=0.
- `waiting`=0 in RUN and MUL_STALL; it is a registered state decode.

**Rules**
- A press requires a rising edge of `db` seen while in WAIT_PRESS. If the button is already held when the WAIT is entered, the block waits for release and a fresh press.
- `PCincr` is never high for more than one consecutive cycle per WAIT instruction.

## Timing

**Reset**
- `rst` low clears state to RUN, and clears `mc`, `dc`, `db`, `db_prev` and both synchroniser flops immediately, without waiting for a clock.
- Outputs under reset: `waiting`=0. `PCincr` decodes as in RUN; this is harmless because the PC is held in reset by the same signal.
- Reset asserted mid-stall or mid-wait aborts the stall or wait. There is no residual count after release.

**Latencies**
- Multiply: a `MUL_OP` presented in RUN gives `PCincr` = 0 for `MUL_CYCLES`-1 cycles, then 1. The PC therefore advances on the `MUL_CYCLES`-th edge.
- Button to `db`: a level change on `btn` held stable reaches `bs` after 2 edges, then `db` after `DEB_CYCLES` further edges.
- `db` to `PCincr`: `db_fall` (and so `PCincr` in WAIT_RELEASE) is high during the cycle after `db` toggles.

**Glitch and stall rules**
- Glitches shorter than `DEB_CYCLES` cycles at `bs` never change `db`.
- Opcode changes during MUL_STALL or the WAIT states have no effect.

## Test plan

Defaults are `MUL_CYCLES`=3, `DEB_CYCLES`=4, with a 10 ns clock.

1. Reset and RUN: assert `rst`=0 for 12 ns with `opcode`=000, then release. Expect `waiting`=0 and `PCincr`=1 on every cycle, so a connected 6-bit PC counts 0, 1, 2, …
2. Multiply stall: present `opcode`=101 in RUN at cycle N. Expect `PCincr` = 0, 0, 1 in cycles N, N+1, N+2, then a return to RUN.
3. Glitch rejection: with `opcode`=110, expect `waiting`=1 from the next cycle. Apply a 2-cycle `btn` pulse. Expect no `db` change, `waiting` still 1 and `PCincr`=0.
4. Press/release: in WAIT, hold `btn`=1 for 10 cycles, then 0 for 10 cycles. Expect exactly one `PCincr`=1 cycle, 7 cycles after the falling `btn` edge (2 sync + 4 debounce + 1). `waiting` then falls.
5. Pre-held button: hold `btn`=1 before `opcode`=110 is presented. Expect no advance until release followed by a fresh press-and-release.
6. Reset mid-stall: assert `rst`=0 in cycle N+1 of a multiply. Expect state RUN and `mc`=0 immediately. After release, `opcode`=000 gives `PCincr`=1.
